// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation encodings, sequencer states and the ALU opcodes it issues.
package muldiv_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration. Shifts {rem, q} left by one, then
// decides from the external ALU's subtract result whether the shifted
// remainder is at least the divisor. The 33rd bit (c) shifted out of rem
// forces a subtract, since the true remainder then exceeds any 32-bit b.
module muldiv_div_step
    import muldiv_pkg::*;
(
    input  logic [31:0] rem,
    input  logic [31:0] q,
    input  logic [31:0] b,
    input  logic [31:0] alu_out,
    input  logic        alu_negative,
    output logic [31:0] s,
    output logic [31:0] rem_nxt,
    output logic [31:0] q_nxt
);

    logic c;
    logic borrow;
    logic sel;

    // Shift, derive unsigned borrow of s - b from signs, select the next rem/q.
    always_comb begin
        c       = rem[31];
        s       = {rem[30:0], q[31]};
        borrow  = (~s[31] & b[31]) | (~(s[31] ^ b[31]) & alu_negative);
        sel     = c | ~borrow;
        rem_nxt = sel ? alu_out : s;
        q_nxt   = {q[30:0], sel};
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MUL / DIVU / REMU sequencer driving the shared execute-stage ALU.
// Divide support is built only when MULDIV_DIV_EN is defined; otherwise
// DIVU/REMU behave like the reserved op (result 0, same latency).
//
// Handshake: start is sampled only while idle (busy=0); the request is then
// owned by the sequencer, busy stays high for 33 cycles, done pulses for one
// cycle together with the new result, and result holds until the next
// accepted operation completes. start while busy is ignored.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [2:0]  alu_opcode,
    output logic [31:0] alu_in_0,
    output logic [31:0] alu_in_1,
    input  logic [31:0] alu_out,
    input  logic        alu_negative
);

    state_t      state;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] acc;
    logic [31:0] acc_nxt;
    logic [31:0] final_res;

`ifdef MULDIV_DIV_EN
    logic [31:0] q;
    logic [31:0] rem;
    logic [31:0] div_s;
    logic [31:0] q_nxt;
    logic [31:0] rem_nxt;

    muldiv_div_step u_div_step (
        .rem          (rem),
        .q            (q),
        .b            (b_q),
        .alu_out      (alu_out),
        .alu_negative (alu_negative),
        .s            (div_s),
        .rem_nxt      (rem_nxt),
        .q_nxt        (q_nxt)
    );
`else
    logic unused_alu_negative;
    assign unused_alu_negative = alu_negative;
`endif

    // ALU operand/opcode selection for the current iteration; idle ALU otherwise.
    always_comb begin
        alu_opcode = ALU_ADD;
        alu_in_0   = '0;
        alu_in_1   = '0;
        acc_nxt    = acc;
        if (state == ST_RUN && op_q == OP_MUL) begin
            alu_in_0 = acc;
            alu_in_1 = a_q << cnt;
            if (b_q[cnt]) acc_nxt = alu_out;
        end
`ifdef MULDIV_DIV_EN
        else if (state == ST_RUN && (op_q == OP_DIVU || op_q == OP_REMU)) begin
            alu_opcode = ALU_SUB;
            alu_in_0   = div_s;
            alu_in_1   = b_q;
        end
`endif
    end

    // Result picked from the post-iteration values of the last RUN cycle.
    always_comb begin
        final_res = '0;
        case (op_q)
            OP_MUL:  final_res = acc_nxt;
`ifdef MULDIV_DIV_EN
            OP_DIVU: final_res = q_nxt;
            OP_REMU: final_res = rem_nxt;
`endif
            default: final_res = '0;
        endcase
    end

    // Sequencer FSM: latch operands, iterate 32 times, publish result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= OP_MUL;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
`ifdef MULDIV_DIV_EN
            q      <= '0;
            rem    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
`ifdef MULDIV_DIV_EN
                        q     <= a;
                        rem   <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    acc <= acc_nxt;
`ifdef MULDIV_DIV_EN
                    q   <= q_nxt;
                    rem <= rem_nxt;
`endif
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        result <= final_res;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq. Models the shared ALU, applies a
// vector table plus random operations, and covers the start-while-busy
// and mid-operation reset corner cases. Honours MULDIV_DIV_EN.
module tb_muldiv_seq;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_in_0;
    logic [31:0] alu_in_1;
    logic [31:0] alu_out;
    logic        alu_negative;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int issued = 0;
    bit sub_seen = 0;
    bit bad_opcode = 0;
    bit idle_alu_bad = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    muldiv_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .alu_opcode   (alu_opcode),
        .alu_in_0     (alu_in_0),
        .alu_in_1     (alu_in_1),
        .alu_out      (alu_out),
        .alu_negative (alu_negative)
    );

    // Shared ALU model: ADD or SUB, combinational.
    assign alu_out      = (alu_opcode == 3'b001) ? (alu_in_0 - alu_in_1) : (alu_in_0 + alu_in_1);
    assign alu_negative = alu_out[31];

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dv(input logic [31:0] v);
`ifdef MULDIV_DIV_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result 0x%08h with no pending operation", result);
            end else begin
                chk("scoreboard_result", result, exp_q.pop_front());
            end
        end
    end

    // ALU-port monitor: legal opcodes only, idle ALU when not busy.
    always @(negedge clk) begin
        if (rst_n) begin
            if (alu_opcode == 3'b001) sub_seen = 1'b1;
            if (alu_opcode != 3'b000 && alu_opcode != 3'b001) bad_opcode = 1'b1;
            if (!busy && (alu_opcode != 3'b000 || alu_in_0 != 32'd0 || alu_in_1 != 32'd0))
                idle_alu_bad = 1'b1;
        end
    end

    // Driver: issue one op, optionally poke start at RUN cycle inject_at,
    // and check busy window, done latency, busy fall and result hold.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] e, input int inject_at);
        bit seen;
        bit busy_bad;
        int lat;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        exp_q.push_back(e);
        issued++;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        seen     = 1'b0;
        busy_bad = 1'b0;
        lat      = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (k == inject_at) begin
                start = 1'b1;
                op    = OP_DIVU;
                a     = 32'd100;
                b     = 32'd7;
            end else if (k == inject_at + 1) begin
                start = 1'b0;
            end
            if (!busy) busy_bad = 1'b1;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done within 40 cycles for op %0d", o);
        end else begin
            chk("done_latency", lat, 33);
            chk("busy_window", {31'd0, busy_bad}, 32'd0);
        end
        @(negedge clk);
        chk("busy_fall", {30'd0, busy, done}, 32'd0);
        chk("result_hold", result, e);
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        logic [1:0]  o;

        vecs[0]  = '{OP_MUL,  32'd7,          32'd6,          32'd42};
        vecs[1]  = '{OP_MUL,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
        vecs[2]  = '{OP_MUL,  32'h8000_0000,  32'd2,          32'h0000_0000};
        vecs[3]  = '{OP_MUL,  32'd0,          32'd12345,      32'd0};
        vecs[4]  = '{OP_MUL,  32'h1234_5678,  32'd1,          32'h1234_5678};
        vecs[5]  = '{OP_DIVU, 32'd100,        32'd7,          dv(32'd14)};
        vecs[6]  = '{OP_REMU, 32'd100,        32'd7,          dv(32'd2)};
        vecs[7]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0000,  dv(32'd1)};
        vecs[8]  = '{OP_REMU, 32'hFFFF_FFFF,  32'h8000_0000,  dv(32'h7FFF_FFFF)};
        vecs[9]  = '{OP_DIVU, 32'h1234,       32'd0,          dv(32'hFFFF_FFFF)};
        vecs[10] = '{OP_REMU, 32'h1234,       32'd0,          dv(32'h1234)};
        vecs[11] = '{OP_DIVU, 32'd7,          32'd100,        dv(32'd0)};
        vecs[12] = '{OP_REMU, 32'd7,          32'd100,        dv(32'd7)};
        vecs[13] = '{OP_RSVD, 32'd5,          32'd5,          32'd0};
        vecs[14] = '{OP_MUL,  32'hDEAD_BEEF,  32'h0000_0100,  32'hADBE_EF00};

        rst_n = 1'b0;
        start = 1'b0;
        op    = OP_MUL;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy",     {31'd0, busy}, 32'd0);
        chk("reset_done",     {31'd0, done}, 32'd0);
        chk("reset_result",   result, 32'd0);
        chk("reset_alu_op",   {29'd0, alu_opcode}, 32'd0);
        chk("reset_alu_in_0", alu_in_0, 32'd0);
        chk("reset_alu_in_1", alu_in_1, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

        // Random operations against bench arithmetic.
        for (int i = 0; i < 8; i++) begin
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            if (y == 32'd0) y = 32'd3;
            o = 2'($urandom_range(0, 2));
            case (o)
                OP_MUL:  run_op(o, x, y, x * y, 0);
                OP_DIVU: run_op(o, x, y, dv(x / y), 0);
                default: run_op(o, x, y, dv(x % y), 0);
            endcase
        end

        // start pulsed at RUN cycle 5 must be ignored.
        run_op(OP_MUL, 32'd7, 32'd6, 32'd42, 5);
        repeat (40) @(negedge clk);
        chk("ignored_start_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1;
        op    = OP_MUL;
        a     = 32'd3;
        b     = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",   {31'd0, busy}, 32'd0);
        chk("midrst_done",   {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_alu_in_0", alu_in_0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_reset_busy",   {31'd0, busy}, 32'd0);
        chk("post_reset_result", result, 32'd0);

        // Closing checks.
        chk("done_count", done_cnt, issued);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("opcode_legal", {31'd0, bad_opcode}, 32'd0);
        chk("idle_alu_zero", {31'd0, idle_alu_bad}, 32'd0);
`ifdef MULDIV_DIV_EN
        chk("sub_used", {31'd0, sub_seen}, 32'd1);
`else
        chk("no_sub", {31'd0, sub_seen}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
